// File: rtl/dds_lut_scheduler.sv
// dds_lut_scheduler: time-multiplexes one registered quarter-wave sine LUT
// among NUM_CH DDS channels visited round-robin.
// Each channel has its own phase accumulator and frequency tuning word.
// The top two phase bits choose the quadrant.
// The LUT address is mirrored in quadrants 1 and 3.
// The sample is negated in quadrants 2 and 3.
// Latency from issue to sample_out is 2 cycles.
// Optional build macro: DDS_PHASE_OFFSET_EN adds per-channel phase offset
// registers, which are written through poff_we/poff_ch/poff_data.
module dds_lut_scheduler #(
   parameter int NUM_CH      = 4,
   parameter int CH_WIDTH    = 2,
   parameter int PHASE_WIDTH = 24,
   parameter int LUT_AW      = 8,
   parameter int LUT_DW      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       ftw_we,
   input  logic [CH_WIDTH-1:0]        ftw_ch,
   input  logic [PHASE_WIDTH-1:0]     ftw_data,
`ifdef DDS_PHASE_OFFSET_EN
   input  logic                       poff_we,
   input  logic [CH_WIDTH-1:0]        poff_ch,
   input  logic [PHASE_WIDTH-1:0]     poff_data,
`endif
   output logic [LUT_AW-1:0]          lut_addr,
   input  logic [LUT_DW-1:0]          lut_data,
   output logic signed [LUT_DW:0]     sample_out,
   output logic [CH_WIDTH-1:0]        sample_ch,
   output logic                       sample_valid
);

   localparam int SH = PHASE_WIDTH - LUT_AW - 2;

   logic [PHASE_WIDTH-1:0] acc [NUM_CH];
   logic [PHASE_WIDTH-1:0] ftw [NUM_CH];
`ifdef DDS_PHASE_OFFSET_EN
   logic [PHASE_WIDTH-1:0] poff [NUM_CH];
`endif

   logic [CH_WIDTH-1:0] slot;
   logic [LUT_AW+1:0]   phase_top;
   logic [1:0]          quad;
   logic [LUT_AW-1:0]   idx;
   logic [LUT_AW-1:0]   fold_addr;

   logic                s1_valid, s2_valid;
   logic                s1_neg, s2_neg;
   logic [CH_WIDTH-1:0] s1_ch, s2_ch;
   logic [LUT_DW:0]     mag;

   // Select the issuing channel's phase and keep only the quadrant/index bits
   always_comb begin
      logic [PHASE_WIDTH-1:0] ph;
      ph = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (slot == CH_WIDTH'(i)) begin
`ifdef DDS_PHASE_OFFSET_EN
            ph = acc[i] + poff[i];
`else
            ph = acc[i];
`endif
         end
      end
      phase_top = (LUT_AW+2)'(ph >> SH);
      quad      = phase_top[LUT_AW+1:LUT_AW];
      idx       = phase_top[LUT_AW-1:0];
      fold_addr = quad[0] ? ~idx : idx;
   end

   // Per-channel tuning words and accumulators. The increment reads the old FTW
   // when a write and an issue hit the same channel on one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            ftw[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ftw_we && ftw_ch == CH_WIDTH'(i))
               ftw[i] <= ftw_data;
            if (enable && slot == CH_WIDTH'(i))
               acc[i] <= acc[i] + ftw[i];
         end
      end
   end

`ifdef DDS_PHASE_OFFSET_EN
   // Per-channel phase offsets. These change only the folded phase, never the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            poff[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if (poff_we && poff_ch == CH_WIDTH'(i))
               poff[i] <= poff_data;
      end
   end
`endif

   // Round-robin slot counter, which advances only on enabled cycles
   always_ff @(posedge clk) begin
      if (rst)
         slot <= '0;
      else if (enable)
         slot <= (slot == CH_WIDTH'(NUM_CH-1)) ? '0 : slot + 1'b1;
   end

   // Issue stage: register the LUT address, sign, channel tag, and valid flag. A stall inserts a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         lut_addr <= '0;
         s1_valid <= 1'b0;
         s1_neg   <= 1'b0;
         s1_ch    <= '0;
      end else begin
         s1_valid <= enable;
         if (enable) begin
            lut_addr <= fold_addr;
            s1_neg   <= quad[1];
            s1_ch    <= slot;
         end
      end
   end

   // Keep the sign, tag, and valid flag aligned with the LUT's registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_neg   <= 1'b0;
         s2_ch    <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_neg   <= s1_neg;
         s2_ch    <= s1_ch;
      end
   end

   assign mag = {1'b0, lut_data};

   // Output stage: apply the sign. Negating zero yields zero. The output holds when no sample is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_out   <= '0;
         sample_ch    <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= s2_valid;
         if (s2_valid) begin
            sample_out <= s2_neg ? -mag : mag;
            sample_ch  <= s2_ch;
         end
      end
   end

endmodule

// File: doc/dds_lut_scheduler.md
Name: dds_lut_scheduler

Overview:
Time-multiplexes one registered quarter-wave sine LUT (2**LUT_AW entries, LUT_DW bits, 0..pi/2, 1-cycle read latency) among NUM_CH DDS channels. Holds a per-channel phase accumulator and frequency tuning word (FTW), visits channels round-robin, and folds each phase into a quadrant-mirrored LUT address. Returns signed full-wave samples tagged with the channel id. Sits between the host/config interface and the sine LUT.

Parameters:
NUM_CH, 4, number of DDS channels (2..2**CH_WIDTH)
CH_WIDTH, 2, channel-id width
PHASE_WIDTH, 24, accumulator/FTW width (must be >= LUT_AW+2)
LUT_AW, 8, LUT address width
LUT_DW, 8, LUT data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  run scheduler; low = stall
ftw_we  in  1  FTW write strobe
ftw_ch  in  CH_WIDTH  FTW target channel
ftw_data  in  PHASE_WIDTH  FTW value
lut_addr  out  LUT_AW  registered address to LUT
lut_data  in  LUT_DW  LUT registered read data
sample_out  out  LUT_DW+1  signed two's-complement sample
sample_ch  out  CH_WIDTH  channel of sample_out
sample_valid  out  1  sample_out/sample_ch valid this cycle

Behaviour:
- Reset (rst high at clk edge): all accumulators, FTWs, slot counter, lut_addr, sample_out, sample_ch, sample_valid, internal pipeline valids/tags -> 0. Reset mid-operation flushes in-flight samples; none emerge afterwards.
- Slot counter c: on each edge with enable=1, issue channel c, then c <= (c==NUM_CH-1) ? 0 : c+1. enable=0: c, accumulators, lut_addr held; a bubble (valid=0) enters pipeline.
- Issue at edge k: phase p = acc[c] (pre-increment); acc[c] <= acc[c] + ftw[c] mod 2**PHASE_WIDTH. q = p[PW-1:PW-2], idx = p[PW-3:PW-2-LUT_AW].
- Folding: q=0 addr=idx,+; q=1 addr=~idx,+; q=2 addr=idx,-; q=3 addr=~idx,-. lut_addr, sign, channel tag, valid registered at edge k.
- LUT returns data at edge k+1. At edge k+2: sample_out = sign ? -{0,lut_data} : {0,lut_data}; sample_ch = tag; sample_valid = valid. Latency: issue edge -> sample edge = 2 cycles, throughput 1 sample/cycle, each channel updated every NUM_CH enabled cycles.
- sample_out/sample_ch hold last values when sample_valid=0.
- FTW write: ftw[ftw_ch] <= ftw_data at edge with ftw_we=1. Write to channel issued on same edge: that edge's increment uses old FTW; new FTW from next visit. ftw_ch >= NUM_CH: write ignored. Writes accepted regardless of enable.
- lut_data=0 with negative sign yields 0 (no negative zero).

Optional Feature:
DDS_PHASE_OFFSET_EN: adds ports poff_we (in, 1), poff_ch (in, CH_WIDTH), poff_data (in, PHASE_WIDTH) and per-channel offset registers (reset 0, same write rules as FTW). Folded phase = acc[c] + poff[c] mod 2**PHASE_WIDTH; accumulator update unaffected. Without macro: ports and registers absent, phase = acc[c].

Test Plan:
- Reset, enable=1, all FTW=0, bench LUT model -> lut_addr=0 every cycle; sample_ch 0,1,2,3,0,...; sample_valid high from 3rd edge after enable; sample_out=0.
- ftw[0]=0x004000 -> ch0 lut_addr 0,1,2,3... on consecutive ch0 visits (every 4 cycles); other channels stay 0.
- ftw[1]=0x400000 -> ch1 visits: addr 0 (+), 255 (+), 0 (-), 255 (-), repeat; with lut[255]=255 q=3 sample_out=9'h101 (-255).
- enable low for 5 cycles mid-run -> exactly 5 sample_valid=0 cycles, 2 edges delayed; resumes with next channel in order, no accumulator skipped or double-incremented.
- rst pulsed 1 cycle with pipeline full -> sample_valid=0 next cycle and stays 0 until 2 edges after enable issues; accumulators and FTWs read back as 0 (sample sequence restarts as first scenario).
- DDS_PHASE_OFFSET_EN: ftw[2]=0, poff[2]=0xBFC000 -> ch2 lut_addr=255, sample_out=-lut[255]=9'h101 on every visit.
